// File: rtl/siso_loopback_ctrl.sv
// Loopback sequencer for a SISO delay line: serialises a word, recaptures it after DEPTH clocks and compares.
// Result pulses WIDTH+DEPTH+1 cycles after acceptance; o_ready stays low from acceptance until the cycle after o_rvalid.
module siso_loopback_ctrl #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_abort,
    output logic             o_sd,
    output logic             o_shift_en,
    input  logic             i_so,
    output logic             o_rvalid,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_match,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH + DEPTH) + 1;
    localparam logic [CW-1:0] LAST_C = CW'(DEPTH + WIDTH - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             match_q, match_d;
    // Marks the cycles right after a reset edge so o_ready stays low while reset is held.
    logic             rst_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            match_q <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            match_q <= match_d;
            rst_q   <= 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rdata_d    = rdata_q;
        match_d    = match_q;
        o_ready    = 1'b0;
        o_busy     = 1'b0;
        o_shift_en = 1'b0;
        o_sd       = 1'b0;
        o_rvalid   = 1'b0;

        case (state_q)
            IDLE: begin
                o_ready = !rst_q;
                if (i_valid && !rst_q) begin
                    tx_d    = i_data;
                    cnt_d   = '0;
                    rx_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                o_busy     = 1'b1;
                o_shift_en = 1'b1;
                cnt_d      = cnt_q + ONE_C;
                // Bit i goes out at cnt==i and returns DEPTH clocks later; past WIDTH the chain is fed zeros.
                for (int i = 0; i < WIDTH; i++) begin
                    int bi;
                    bi = LSB_FIRST ? i : (WIDTH - 1 - i);
                    if (cnt_q == CW'(i)) begin
                        o_sd = tx_q[bi];
                    end
                    if (cnt_q == CW'(DEPTH + i)) begin
                        rx_d[bi] = i_so;
                    end
                end
                if (i_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_C) begin
                    rdata_d = rx_d;
                    match_d = (rx_d == tx_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                o_rvalid = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_rdata = rdata_q;
    assign o_match = match_q;

endmodule

// File: tb/tb_siso_loopback_ctrl.sv
// Directed bench: two controllers (LSB-first and MSB-first), each looped through a 4-flop SISO model.
module tb_siso_loopback_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [3:0] data;
    logic       abort;
    logic       corrupt;

    logic       ready_a, sd_a, shift_en_a, so_a, rvalid_a, match_a, busy_a;
    logic [3:0] rdata_a;
    logic       ready_b, sd_b, shift_en_b, so_b, rvalid_b, match_b, busy_b;
    logic [3:0] rdata_b;

    logic [3:0] ch_a = '0;
    logic [3:0] ch_b = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    siso_loopback_ctrl #(.WIDTH(4), .DEPTH(4), .LSB_FIRST(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_a), .i_data(data),
        .i_abort(abort), .o_sd(sd_a), .o_shift_en(shift_en_a), .i_so(so_a),
        .o_rvalid(rvalid_a), .o_rdata(rdata_a), .o_match(match_a), .o_busy(busy_a)
    );

    siso_loopback_ctrl #(.WIDTH(4), .DEPTH(4), .LSB_FIRST(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_b), .i_data(data),
        .i_abort(abort), .o_sd(sd_b), .o_shift_en(shift_en_b), .i_so(so_b),
        .o_rvalid(rvalid_b), .o_rdata(rdata_b), .o_match(match_b), .o_busy(busy_b)
    );

    always @(posedge clk) begin
        if (shift_en_a) ch_a <= {ch_a[2:0], sd_a};
        if (shift_en_b) ch_b <= {ch_b[2:0], sd_b};
    end
    assign so_a = corrupt ? 1'b1 : ch_a[3];
    assign so_b = corrupt ? 1'b1 : ch_b[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts at the first RUN cycle, ends in the DONE cycle.
    task automatic run_body(input string nm, input logic [7:0] sdv_a, input logic [7:0] sdv_b,
                            input logic [3:0] rd_a, input logic [3:0] rd_b, input logic m);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s sd_a[%0d]", nm, k), 32'(sd_a), 32'(sdv_a[k]));
            chk($sformatf("%s sd_b[%0d]", nm, k), 32'(sd_b), 32'(sdv_b[k]));
            chk($sformatf("%s shift_en[%0d]", nm, k), 32'(shift_en_a), 32'd1);
            chk($sformatf("%s rvalid_run[%0d]", nm, k), 32'(rvalid_a), 32'd0);
            if (k == 0) begin
                chk($sformatf("%s busy", nm), 32'(busy_a), 32'd1);
                chk($sformatf("%s ready_run", nm), 32'(ready_a), 32'd0);
            end
            @(negedge clk);
        end
        chk($sformatf("%s rvalid_a", nm), 32'(rvalid_a), 32'd1);
        chk($sformatf("%s rvalid_b", nm), 32'(rvalid_b), 32'd1);
        chk($sformatf("%s rdata_a", nm), 32'(rdata_a), 32'(rd_a));
        chk($sformatf("%s rdata_b", nm), 32'(rdata_b), 32'(rd_b));
        chk($sformatf("%s match_a", nm), 32'(match_a), 32'(m));
        chk($sformatf("%s match_b", nm), 32'(match_b), 32'(m));
        chk($sformatf("%s shift_en_done", nm), 32'(shift_en_a), 32'd0);
        chk($sformatf("%s busy_done", nm), 32'(busy_a), 32'd0);
        chk($sformatf("%s ready_done", nm), 32'(ready_a), 32'd0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; valid = 1'b1; data = 4'h7; abort = 1'b0; corrupt = 1'b0;

        // reset held two cycles with a word on offer
        @(negedge clk);
        chk("rst ready0", 32'(ready_a), 32'd0);
        @(negedge clk);
        chk("rst ready1", 32'(ready_a), 32'd0);
        chk("rst busy", 32'(busy_a), 32'd0);
        rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("post-rst ready", 32'(ready_a), 32'd1);
        chk("post-rst rdata", 32'(rdata_a), 32'd0);
        chk("post-rst rvalid", 32'(rvalid_a), 32'd0);
        chk("post-rst busy", 32'(busy_a), 32'd0);
        chk("post-rst match", 32'(match_a), 32'd0);

        // 4'b1101: LSB-first 1,0,1,1 / MSB-first 1,1,0,1
        valid = 1'b1; data = 4'hD;
        @(negedge clk);
        valid = 1'b0;
        run_body("basic", 8'b0000_1101, 8'b0000_1011, 4'hD, 4'hD, 1'b1);
        @(negedge clk);
        chk("basic rvalid_1cyc", 32'(rvalid_a), 32'd0);
        chk("basic ready_after", 32'(ready_a), 32'd1);
        chk("basic rdata_hold", 32'(rdata_a), 32'hD);

        // stuck-at-1 chain output
        corrupt = 1'b1; valid = 1'b1; data = 4'h5;
        @(negedge clk);
        valid = 1'b0;
        run_body("corrupt", 8'b0000_0101, 8'b0000_1010, 4'hF, 4'hF, 1'b0);
        corrupt = 1'b0;
        @(negedge clk);
        chk("corrupt rvalid_1cyc", 32'(rvalid_a), 32'd0);

        // abort on third RUN cycle
        valid = 1'b1; data = 4'h6;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort ready", 32'(ready_a), 32'd1);
        chk("abort busy", 32'(busy_a), 32'd0);
        chk("abort rvalid", 32'(rvalid_a), 32'd0);
        chk("abort rdata_kept", 32'(rdata_a), 32'hF);
        chk("abort match_kept", 32'(match_a), 32'd0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rvalid_a || rvalid_b) pulses++;
        end
        chk("abort no_rvalid", 32'(pulses), 32'd0);
        valid = 1'b1; data = 4'hA;
        @(negedge clk);
        valid = 1'b0;
        run_body("after_abort", 8'b0000_1010, 8'b0000_0101, 4'hA, 4'hA, 1'b1);

        // back-to-back with i_valid held high
        @(negedge clk);
        valid = 1'b1; data = 4'h3;
        @(negedge clk);
        data = 4'hC;
        run_body("b2b_3", 8'b0000_0011, 8'b0000_1100, 4'h3, 4'h3, 1'b1);
        @(negedge clk);
        chk("b2b idle_ready", 32'(ready_a), 32'd1);
        chk("b2b idle_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        run_body("b2b_C", 8'b0000_1100, 8'b0000_0011, 4'hC, 4'hC, 1'b1);

        // reset pulsed mid-RUN
        @(negedge clk);
        valid = 1'b1; data = 4'h9;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 32'(busy_a), 32'd0);
        chk("midrst shift_en", 32'(shift_en_a), 32'd0);
        chk("midrst sd", 32'(sd_a), 32'd0);
        chk("midrst rvalid", 32'(rvalid_a), 32'd0);
        chk("midrst rdata", 32'(rdata_a), 32'd0);
        chk("midrst match", 32'(match_a), 32'd0);
        chk("midrst ready_in_rst", 32'(ready_a), 32'd0);
        @(negedge clk);
        chk("midrst ready_after", 32'(ready_a), 32'd1);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (rvalid_a || rvalid_b) pulses++;
        end
        chk("midrst no_rvalid", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
